control: RTL and testbench

CONTROL -- requirements
Module: control

---
 rtl/rv32i_types.sv | 63 ++++++
 rtl/control_memalign.sv | 39 +++
 rtl/control.sv | 261 ++++++++++++++++++++++++++
 tb/tb_control.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | rv32i_types : shared state, opcode and datapath select encodings for control
// | Revision    : 1.0
// +----------------------------------------------------------------------------
package rv32i_types;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011
  } rv32i_opcode_t;

  typedef enum logic [3:0] {
    FETCH1, FETCH2, FETCH3, DECODE, IMM, REG, LUI, AUIPC,
    BR, JAL, JALR, CALC_ADDR, LD1, LD2, ST1, ST2
  } state_t;

  typedef enum logic [1:0] {pcmux_pc_plus4, pcmux_alu_out, pcmux_alu_mod2} pcmux_sel_t;
  typedef enum logic {alumux1_rs1_out, alumux1_pc_out} alumux1_sel_t;
  typedef enum logic [2:0] {
    alumux2_i_imm, alumux2_u_imm, alumux2_b_imm, alumux2_s_imm, alumux2_j_imm, alumux2_rs2_out
  } alumux2_sel_t;
  typedef enum logic [3:0] {
    regfilemux_alu_out, regfilemux_br_en, regfilemux_u_imm, regfilemux_lw, regfilemux_pc_plus4,
    regfilemux_lb, regfilemux_lbu, regfilemux_lh, regfilemux_lhu
  } regfilemux_sel_t;
  typedef enum logic {marmux_pc_out, marmux_alu_out} marmux_sel_t;
  typedef enum logic {cmpmux_rs2_out, cmpmux_i_imm} cmpmux_sel_t;

  // ALU encodings line up with funct3 for every op that has no funct7 variant.
  typedef enum logic [2:0] {
    alu_add, alu_sll, alu_sra, alu_sub, alu_xor, alu_srl, alu_or, alu_and
  } alu_ops;

  typedef enum logic [2:0] {
    cmp_beq = 3'b000, cmp_bne = 3'b001, cmp_blt = 3'b100,
    cmp_bge = 3'b101, cmp_bltu = 3'b110, cmp_bgeu = 3'b111
  } cmp_ops;

  localparam logic [2:0] c_F3_ADD  = 3'b000;
  localparam logic [2:0] c_F3_SLT  = 3'b010;
  localparam logic [2:0] c_F3_SLTU = 3'b011;
  localparam logic [2:0] c_F3_SR   = 3'b101;

  localparam logic [2:0] c_F3_LB  = 3'b000;
  localparam logic [2:0] c_F3_LH  = 3'b001;
  localparam logic [2:0] c_F3_LW  = 3'b010;
  localparam logic [2:0] c_F3_LBU = 3'b100;
  localparam logic [2:0] c_F3_LHU = 3'b101;

  localparam logic [2:0] c_F3_SB = 3'b000;
  localparam logic [2:0] c_F3_SH = 3'b001;
  localparam logic [2:0] c_F3_SW = 3'b010;

endpackage
`default_nettype wire

// File: rtl/control_memalign.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | control_memalign : load extension select and store byte-enable decode
// | Revision         : 1.0
// +----------------------------------------------------------------------------
module control_memalign
  import rv32i_types::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      mar_lo,
  output regfilemux_sel_t load_sel,
  output logic [3:0]      store_be
);

  // The datapath shifts MDR by mar_lo; this only picks width and signedness.
  always_comb begin
    load_sel = regfilemux_lw;
    case (funct3)
      c_F3_LB:  load_sel = regfilemux_lb;
      c_F3_LH:  load_sel = regfilemux_lh;
      c_F3_LW:  load_sel = regfilemux_lw;
      c_F3_LBU: load_sel = regfilemux_lbu;
      c_F3_LHU: load_sel = regfilemux_lhu;
      default:  load_sel = regfilemux_lw;
    endcase
  end

  always_comb begin
    store_be = 4'b0000;
    case (funct3)
      c_F3_SB: store_be = 4'b0001 << mar_lo;
      c_F3_SH: store_be = 4'b0011 << mar_lo;
      c_F3_SW: store_be = 4'b1111;
      default: store_be = 4'b0000;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/control.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | control : multicycle RV32I control FSM; CONTROL_WATCHDOG_EN adds a memory watchdog
// | Revision : 1.0
// +----------------------------------------------------------------------------
module control
  import rv32i_types::*;
#(
  parameter int WATCHDOG_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic            br_en,
  input  logic [1:0]      mar_lo,
  input  logic            mem_resp,
  output logic            load_pc,
  output logic            load_ir,
  output logic            load_regfile,
  output logic            load_mar,
  output logic            load_mdr,
  output logic            load_data_out,
  output pcmux_sel_t      pcmux_sel,
  output alumux1_sel_t    alumux1_sel,
  output alumux2_sel_t    alumux2_sel,
  output regfilemux_sel_t regfilemux_sel,
  output marmux_sel_t     marmux_sel,
  output cmpmux_sel_t     cmpmux_sel,
  output alu_ops          aluop,
  output cmp_ops          cmpop,
  output logic            mem_read,
  output logic            mem_write,
  output logic [3:0]      mem_byte_enable,
  output logic            mem_timeout
);

  state_t          r_state;
  state_t          w_next_state;
  regfilemux_sel_t w_load_sel;
  logic [3:0]      w_store_be;
  logic            w_wd_expired;
  logic            w_unused_funct7;

  assign w_unused_funct7 = ^{funct7[6], funct7[4:0]};

  control_memalign u_memalign (
    .funct3   (funct3),
    .mar_lo   (mar_lo),
    .load_sel (w_load_sel),
    .store_be (w_store_be)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= FETCH1;
    else      r_state <= w_next_state;
  end

`ifdef CONTROL_WATCHDOG_EN
  localparam int c_WD_W = $clog2(WATCHDOG_CYCLES + 1);

  logic [c_WD_W-1:0] r_wd_cnt;
  logic              w_in_mem;

  assign w_in_mem     = (r_state == FETCH2) || (r_state == LD1) || (r_state == ST1);
  assign w_wd_expired = w_in_mem && !mem_resp && (r_wd_cnt == c_WD_W'(WATCHDOG_CYCLES - 1));

  // Counts completed wait cycles; cleared on response, timeout or leaving a memory state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                   r_wd_cnt <= '0;
    else if (w_in_mem && !mem_resp && !w_wd_expired) r_wd_cnt <= r_wd_cnt + 1'b1;
    else                                        r_wd_cnt <= '0;
  end
`else
  logic [31:0] w_unused_wd_limit;

  assign w_unused_wd_limit = 32'(WATCHDOG_CYCLES);
  assign w_wd_expired      = 1'b0;
`endif

  always_comb begin
    w_next_state    = r_state;
    load_pc         = 1'b0;
    load_ir         = 1'b0;
    load_regfile    = 1'b0;
    load_mar        = 1'b0;
    load_mdr        = 1'b0;
    load_data_out   = 1'b0;
    pcmux_sel       = pcmux_pc_plus4;
    alumux1_sel     = alumux1_rs1_out;
    alumux2_sel     = alumux2_i_imm;
    regfilemux_sel  = regfilemux_alu_out;
    marmux_sel      = marmux_pc_out;
    cmpmux_sel      = cmpmux_rs2_out;
    aluop           = alu_add;
    cmpop           = cmp_beq;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = 4'b0000;
    mem_timeout     = 1'b0;

    // Outputs stay at defaults for as long as reset is held.
    if (rst) begin
      case (r_state)
        FETCH1: begin
          load_mar     = 1'b1;
          w_next_state = FETCH2;
        end
        FETCH2: begin
          mem_read = 1'b1;
          load_mdr = 1'b1;
          if (w_wd_expired) begin
            mem_timeout  = 1'b1;
            w_next_state = FETCH1;
          end else if (mem_resp) begin
            w_next_state = FETCH3;
          end
        end
        FETCH3: begin
          load_ir      = 1'b1;
          w_next_state = DECODE;
        end
        DECODE: begin
          case (opcode)
            op_lui:            w_next_state = LUI;
            op_auipc:          w_next_state = AUIPC;
            op_jal:            w_next_state = JAL;
            op_jalr:           w_next_state = JALR;
            op_br:             w_next_state = BR;
            op_load, op_store: w_next_state = CALC_ADDR;
            op_reg:            w_next_state = REG;
            default:           w_next_state = IMM;
          endcase
        end
        IMM: begin
          // Unknown opcodes also land here and only advance the PC.
          load_pc      = 1'b1;
          w_next_state = FETCH1;
          if (opcode == op_imm) begin
            load_regfile = 1'b1;
            case (funct3)
              c_F3_SLT: begin
                cmpop          = cmp_blt;
                cmpmux_sel     = cmpmux_i_imm;
                regfilemux_sel = regfilemux_br_en;
              end
              c_F3_SLTU: begin
                cmpop          = cmp_bltu;
                cmpmux_sel     = cmpmux_i_imm;
                regfilemux_sel = regfilemux_br_en;
              end
              c_F3_SR: aluop = funct7[5] ? alu_sra : alu_srl;
              default: aluop = alu_ops'(funct3);
            endcase
          end
        end
        REG: begin
          load_pc      = 1'b1;
          load_regfile = 1'b1;
          alumux2_sel  = alumux2_rs2_out;
          w_next_state = FETCH1;
          case (funct3)
            c_F3_ADD: aluop = funct7[5] ? alu_sub : alu_add;
            c_F3_SLT: begin
              cmpop          = cmp_blt;
              regfilemux_sel = regfilemux_br_en;
            end
            c_F3_SLTU: begin
              cmpop          = cmp_bltu;
              regfilemux_sel = regfilemux_br_en;
            end
            c_F3_SR: aluop = funct7[5] ? alu_sra : alu_srl;
            default: aluop = alu_ops'(funct3);
          endcase
        end
        LUI: begin
          load_pc        = 1'b1;
          load_regfile   = 1'b1;
          regfilemux_sel = regfilemux_u_imm;
          w_next_state   = FETCH1;
        end
        AUIPC: begin
          load_pc      = 1'b1;
          load_regfile = 1'b1;
          alumux1_sel  = alumux1_pc_out;
          alumux2_sel  = alumux2_u_imm;
          w_next_state = FETCH1;
        end
        BR: begin
          load_pc      = 1'b1;
          pcmux_sel    = br_en ? pcmux_alu_out : pcmux_pc_plus4;
          alumux1_sel  = alumux1_pc_out;
          alumux2_sel  = alumux2_b_imm;
          cmpop        = cmp_ops'(funct3);
          w_next_state = FETCH1;
        end
        JAL: begin
          load_pc        = 1'b1;
          pcmux_sel      = pcmux_alu_out;
          load_regfile   = 1'b1;
          regfilemux_sel = regfilemux_pc_plus4;
          alumux1_sel    = alumux1_pc_out;
          alumux2_sel    = alumux2_j_imm;
          w_next_state   = FETCH1;
        end
        JALR: begin
          load_pc        = 1'b1;
          pcmux_sel      = pcmux_alu_mod2;
          load_regfile   = 1'b1;
          regfilemux_sel = regfilemux_pc_plus4;
          w_next_state   = FETCH1;
        end
        CALC_ADDR: begin
          load_mar   = 1'b1;
          marmux_sel = marmux_alu_out;
          if (opcode == op_store) begin
            alumux2_sel   = alumux2_s_imm;
            load_data_out = 1'b1;
            w_next_state  = ST1;
          end else begin
            w_next_state = LD1;
          end
        end
        LD1: begin
          mem_read = 1'b1;
          load_mdr = 1'b1;
          if (w_wd_expired) begin
            mem_timeout  = 1'b1;
            w_next_state = FETCH1;
          end else if (mem_resp) begin
            w_next_state = LD2;
          end
        end
        LD2: begin
          load_pc        = 1'b1;
          load_regfile   = 1'b1;
          regfilemux_sel = w_load_sel;
          w_next_state   = FETCH1;
        end
        ST1: begin
          mem_write       = 1'b1;
          mem_byte_enable = w_store_be;
          if (w_wd_expired) begin
            mem_timeout  = 1'b1;
            w_next_state = FETCH1;
          end else if (mem_resp) begin
            w_next_state = ST2;
          end
        end
        ST2: begin
          load_pc      = 1'b1;
          w_next_state = FETCH1;
        end
        default: w_next_state = FETCH1;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_control.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | tb_control : directed scoreboard bench for the control FSM
// | Revision   : 1.0
// +----------------------------------------------------------------------------
module tb_control;
  import rv32i_types::*;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [6:0]      opcode = '0;
  logic [2:0]      funct3 = '0;
  logic [6:0]      funct7 = '0;
  logic            br_en = 1'b0;
  logic [1:0]      mar_lo = '0;
  logic            mem_resp = 1'b0;
  logic [31:0]     mdr = '0;

  logic            load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out;
  pcmux_sel_t      pcmux_sel;
  alumux1_sel_t    alumux1_sel;
  alumux2_sel_t    alumux2_sel;
  regfilemux_sel_t regfilemux_sel;
  marmux_sel_t     marmux_sel;
  cmpmux_sel_t     cmpmux_sel;
  alu_ops          aluop;
  cmp_ops          cmpop;
  logic            mem_read, mem_write, mem_timeout;
  logic [3:0]      mem_byte_enable;

  control #(.WATCHDOG_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .br_en(br_en), .mar_lo(mar_lo), .mem_resp(mem_resp),
    .load_pc(load_pc), .load_ir(load_ir), .load_regfile(load_regfile),
    .load_mar(load_mar), .load_mdr(load_mdr), .load_data_out(load_data_out),
    .pcmux_sel(pcmux_sel), .alumux1_sel(alumux1_sel), .alumux2_sel(alumux2_sel),
    .regfilemux_sel(regfilemux_sel), .marmux_sel(marmux_sel), .cmpmux_sel(cmpmux_sel),
    .aluop(aluop), .cmpop(cmpop), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  typedef enum int {
    S_LOAD_PC, S_LOAD_IR, S_LOAD_RF, S_LOAD_MAR, S_LOAD_MDR, S_LOAD_DOUT,
    S_PCMUX, S_ALUMUX1, S_ALUMUX2, S_RFMUX, S_MARMUX, S_CMPMUX, S_ALUOP, S_CMPOP,
    S_MEM_RD, S_MEM_WR, S_MEM_BE, S_TIMEOUT, S_RD
  } sig_t;

  typedef struct {
    int          cyc;
    sig_t        sig;
    logic [31:0] exp;
  } exp_t;

  exp_t  q[$];
  string qn[$];
  int    cyc = 0;
  int    n_checks = 0;
  int    n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference datapath load path: shift MDR by mar_lo, then extend.
  function automatic logic [31:0] model_rd(regfilemux_sel_t sel, logic [31:0] word, logic [1:0] lo);
    logic [31:0] sh;
    sh = word >> (8 * lo);
    case (sel)
      regfilemux_lb:  return {{24{sh[7]}}, sh[7:0]};
      regfilemux_lbu: return {24'h0, sh[7:0]};
      regfilemux_lh:  return {{16{sh[15]}}, sh[15:0]};
      regfilemux_lhu: return {16'h0, sh[15:0]};
      regfilemux_lw:  return word;
      default:        return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic logic [31:0] actual(sig_t s);
    case (s)
      S_LOAD_PC:   return 32'(load_pc);
      S_LOAD_IR:   return 32'(load_ir);
      S_LOAD_RF:   return 32'(load_regfile);
      S_LOAD_MAR:  return 32'(load_mar);
      S_LOAD_MDR:  return 32'(load_mdr);
      S_LOAD_DOUT: return 32'(load_data_out);
      S_PCMUX:     return 32'(pcmux_sel);
      S_ALUMUX1:   return 32'(alumux1_sel);
      S_ALUMUX2:   return 32'(alumux2_sel);
      S_RFMUX:     return 32'(regfilemux_sel);
      S_MARMUX:    return 32'(marmux_sel);
      S_CMPMUX:    return 32'(cmpmux_sel);
      S_ALUOP:     return 32'(aluop);
      S_CMPOP:     return 32'(cmpop);
      S_MEM_RD:    return 32'(mem_read);
      S_MEM_WR:    return 32'(mem_write);
      S_MEM_BE:    return 32'(mem_byte_enable);
      S_TIMEOUT:   return 32'(mem_timeout);
      S_RD:        return model_rd(regfilemux_sel, mdr, mar_lo);
      default:     return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Monitor: consume every expectation tagged with the current cycle.
  always @(negedge clk) begin : monitor
    exp_t        e;
    string       nm;
    logic [31:0] act;
    if (rst) begin
      n_checks++;
      if (mem_read && mem_write) begin
        n_errors++;
        $display("FAIL mem_rw_exclusive: actual read=%0b write=%0b required not both (cycle %0d)",
                 mem_read, mem_write, cyc);
      end
    end
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e  = q.pop_front();
      nm = qn.pop_front();
      n_checks++;
      if (e.cyc < cyc) begin
        n_errors++;
        $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", nm, e.cyc, cyc);
      end else begin
        act = actual(e.sig);
        if (act !== e.exp) begin
          n_errors++;
          $display("FAIL %s: actual=0x%08h required=0x%08h (cycle %0d)", nm, act, e.exp, e.cyc);
        end
      end
    end
  end

  task automatic expect_sig(input string nm, input sig_t s, input logic [31:0] v);
    exp_t e;
    e.cyc = cyc;
    e.sig = s;
    e.exp = v;
    q.push_back(e);
    qn.push_back(nm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    opcode = op;
    funct3 = f3;
    funct7 = f7;
  endtask

  // Starts in FETCH1, ends with the execute state as the current cycle.
  task automatic do_fetch(input string tag, input int lat);
    expect_sig({tag, ".f1_load_mar"}, S_LOAD_MAR, 32'd1);
    expect_sig({tag, ".f1_marmux"}, S_MARMUX, 32'(marmux_pc_out));
    step();
    for (int i = 0; i < lat; i++) begin
      mem_resp = (i == lat - 1);
      expect_sig({tag, ".f2_mem_read"}, S_MEM_RD, 32'd1);
      expect_sig({tag, ".f2_load_mdr"}, S_LOAD_MDR, 32'd1);
      expect_sig({tag, ".f2_load_ir"}, S_LOAD_IR, 32'd0);
      step();
    end
    mem_resp = 1'b0;
    expect_sig({tag, ".f3_load_ir"}, S_LOAD_IR, 32'd1);
    expect_sig({tag, ".f3_mem_read"}, S_MEM_RD, 32'd0);
    step();
    expect_sig({tag, ".dec_load_pc"}, S_LOAD_PC, 32'd0);
    expect_sig({tag, ".dec_load_rf"}, S_LOAD_RF, 32'd0);
    expect_sig({tag, ".dec_load_mar"}, S_LOAD_MAR, 32'd0);
    step();
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [1:0] lo,
                          input logic [3:0] be);
    set_ir(op_store, f3, 7'd0);
    mar_lo = lo;
    do_fetch(tag, 1);
    expect_sig({tag, ".ca_load_mar"}, S_LOAD_MAR, 32'd1);
    expect_sig({tag, ".ca_marmux"}, S_MARMUX, 32'(marmux_alu_out));
    expect_sig({tag, ".ca_load_dout"}, S_LOAD_DOUT, 32'd1);
    expect_sig({tag, ".ca_alumux2"}, S_ALUMUX2, 32'(alumux2_s_imm));
    step();
    for (int i = 0; i < 2; i++) begin
      mem_resp = (i == 1);
      expect_sig({tag, ".st1_mem_write"}, S_MEM_WR, 32'd1);
      expect_sig({tag, ".st1_mem_read"}, S_MEM_RD, 32'd0);
      expect_sig({tag, ".st1_be"}, S_MEM_BE, 32'(be));
      step();
    end
    mem_resp = 1'b0;
    expect_sig({tag, ".st2_load_pc"}, S_LOAD_PC, 32'd1);
    expect_sig({tag, ".st2_be"}, S_MEM_BE, 32'd0);
    expect_sig({tag, ".st2_mem_write"}, S_MEM_WR, 32'd0);
    step();
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [1:0] lo,
                         input logic [31:0] word, input regfilemux_sel_t sel, input logic [31:0] rd);
    set_ir(op_load, f3, 7'd0);
    mar_lo = lo;
    mdr    = word;
    do_fetch(tag, 1);
    expect_sig({tag, ".ca_load_mar"}, S_LOAD_MAR, 32'd1);
    expect_sig({tag, ".ca_load_dout"}, S_LOAD_DOUT, 32'd0);
    step();
    for (int i = 0; i < 2; i++) begin
      mem_resp = (i == 1);
      expect_sig({tag, ".ld1_mem_read"}, S_MEM_RD, 32'd1);
      expect_sig({tag, ".ld1_load_mdr"}, S_LOAD_MDR, 32'd1);
      expect_sig({tag, ".ld1_be"}, S_MEM_BE, 32'd0);
      step();
    end
    mem_resp = 1'b0;
    expect_sig({tag, ".ld2_load_rf"}, S_LOAD_RF, 32'd1);
    expect_sig({tag, ".ld2_rfmux"}, S_RFMUX, 32'(sel));
    expect_sig({tag, ".ld2_load_pc"}, S_LOAD_PC, 32'd1);
    expect_sig({tag, ".ld2_rd"}, S_RD, rd);
    step();
  endtask

  initial begin
    // Reset held: every output at its default.
    step();
    step();
    expect_sig("rst.load_mar", S_LOAD_MAR, 32'd0);
    expect_sig("rst.mem_read", S_MEM_RD, 32'd0);
    expect_sig("rst.load_pc", S_LOAD_PC, 32'd0);
    step();
    rst = 1'b1;

    // ADDI with funct7[5] set still adds; fetch answers on the third wait cycle.
    set_ir(op_imm, 3'b000, 7'b0100000);
    do_fetch("addi", 3);
    expect_sig("addi.load_rf", S_LOAD_RF, 32'd1);
    expect_sig("addi.aluop", S_ALUOP, 32'(alu_add));
    expect_sig("addi.load_pc", S_LOAD_PC, 32'd1);
    expect_sig("addi.pcmux", S_PCMUX, 32'(pcmux_pc_plus4));
    expect_sig("addi.alumux2", S_ALUMUX2, 32'(alumux2_i_imm));
    expect_sig("addi.rfmux", S_RFMUX, 32'(regfilemux_alu_out));
    step();

    set_ir(op_reg, 3'b000, 7'b0100000);
    do_fetch("sub", 1);
    expect_sig("sub.aluop", S_ALUOP, 32'(alu_sub));
    expect_sig("sub.alumux2", S_ALUMUX2, 32'(alumux2_rs2_out));
    expect_sig("sub.load_rf", S_LOAD_RF, 32'd1);
    step();

    set_ir(op_imm, 3'b101, 7'b0100000);
    do_fetch("srai", 2);
    expect_sig("srai.aluop", S_ALUOP, 32'(alu_sra));
    step();

    set_ir(op_reg, 3'b101, 7'b0000000);
    do_fetch("srl", 1);
    expect_sig("srl.aluop", S_ALUOP, 32'(alu_srl));
    step();

    set_ir(op_reg, 3'b011, 7'b0000000);
    do_fetch("sltu", 1);
    expect_sig("sltu.rfmux", S_RFMUX, 32'(regfilemux_br_en));
    expect_sig("sltu.cmpop", S_CMPOP, 32'(cmp_bltu));
    expect_sig("sltu.cmpmux", S_CMPMUX, 32'(cmpmux_rs2_out));
    step();

    set_ir(op_imm, 3'b010, 7'b0000000);
    do_fetch("slti", 1);
    expect_sig("slti.cmpop", S_CMPOP, 32'(cmp_blt));
    expect_sig("slti.cmpmux", S_CMPMUX, 32'(cmpmux_i_imm));
    expect_sig("slti.rfmux", S_RFMUX, 32'(regfilemux_br_en));
    step();

    set_ir(op_br, 3'b000, 7'd0);
    br_en = 1'b1;
    do_fetch("beq_t", 1);
    expect_sig("beq_t.pcmux", S_PCMUX, 32'(pcmux_alu_out));
    expect_sig("beq_t.load_pc", S_LOAD_PC, 32'd1);
    expect_sig("beq_t.load_rf", S_LOAD_RF, 32'd0);
    expect_sig("beq_t.alumux1", S_ALUMUX1, 32'(alumux1_pc_out));
    expect_sig("beq_t.alumux2", S_ALUMUX2, 32'(alumux2_b_imm));
    step();
    br_en = 1'b0;
    do_fetch("beq_n", 1);
    expect_sig("beq_n.pcmux", S_PCMUX, 32'(pcmux_pc_plus4));
    expect_sig("beq_n.load_pc", S_LOAD_PC, 32'd1);
    step();

    set_ir(op_jalr, 3'b000, 7'd0);
    do_fetch("jalr", 1);
    expect_sig("jalr.pcmux", S_PCMUX, 32'(pcmux_alu_mod2));
    expect_sig("jalr.rfmux", S_RFMUX, 32'(regfilemux_pc_plus4));
    expect_sig("jalr.load_rf", S_LOAD_RF, 32'd1);
    step();

    set_ir(op_jal, 3'b000, 7'd0);
    do_fetch("jal", 1);
    expect_sig("jal.pcmux", S_PCMUX, 32'(pcmux_alu_out));
    expect_sig("jal.alumux2", S_ALUMUX2, 32'(alumux2_j_imm));
    expect_sig("jal.rfmux", S_RFMUX, 32'(regfilemux_pc_plus4));
    step();

    set_ir(op_lui, 3'b000, 7'd0);
    do_fetch("lui", 1);
    expect_sig("lui.rfmux", S_RFMUX, 32'(regfilemux_u_imm));
    expect_sig("lui.load_pc", S_LOAD_PC, 32'd1);
    step();

    set_ir(op_auipc, 3'b000, 7'd0);
    do_fetch("auipc", 1);
    expect_sig("auipc.alumux1", S_ALUMUX1, 32'(alumux1_pc_out));
    expect_sig("auipc.alumux2", S_ALUMUX2, 32'(alumux2_u_imm));
    step();

    set_ir(7'b1111111, 3'b000, 7'd0);
    do_fetch("illegal", 1);
    expect_sig("illegal.load_pc", S_LOAD_PC, 32'd1);
    expect_sig("illegal.pcmux", S_PCMUX, 32'(pcmux_pc_plus4));
    expect_sig("illegal.load_rf", S_LOAD_RF, 32'd0);
    step();

    do_store("sb", 3'b000, 2'd2, 4'b0100);
    do_store("sh", 3'b001, 2'd2, 4'b1100);
    do_store("sw", 3'b010, 2'd1, 4'b1111);

    do_load("lh", 3'b001, 2'd2, 32'h8001_0000, regfilemux_lh, 32'hFFFF_8001);
    do_load("lbu", 3'b100, 2'd3, 32'h8001_0000, regfilemux_lbu, 32'h0000_0080);

    // Reset asserted while LD1 waits on memory.
    set_ir(op_load, 3'b010, 7'd0);
    do_fetch("ldrst", 1);
    step();
    expect_sig("ldrst.ld1_mem_read", S_MEM_RD, 32'd1);
    step();
    rst = 1'b0;
    expect_sig("ldrst.rst_mem_read", S_MEM_RD, 32'd0);
    expect_sig("ldrst.rst_load_mdr", S_LOAD_MDR, 32'd0);
    step();
    rst = 1'b1;
    expect_sig("ldrst.fetch1_load_mar", S_LOAD_MAR, 32'd1);
    expect_sig("ldrst.fetch1_mem_read", S_MEM_RD, 32'd0);

    set_ir(op_imm, 3'b000, 7'd0);
`ifdef CONTROL_WATCHDOG_EN
    step();
    for (int i = 0; i < 4; i++) begin
      expect_sig("wd.f2_mem_read", S_MEM_RD, 32'd1);
      expect_sig("wd.timeout", S_TIMEOUT, (i == 3) ? 32'd1 : 32'd0);
      step();
    end
    expect_sig("wd.after_timeout", S_TIMEOUT, 32'd0);
    expect_sig("wd.after_load_pc", S_LOAD_PC, 32'd0);
    do_fetch("wd_retry", 1);
`else
    step();
    for (int i = 0; i < 8; i++) begin
      expect_sig("nowd.f2_mem_read", S_MEM_RD, 32'd1);
      expect_sig("nowd.timeout", S_TIMEOUT, 32'd0);
      step();
    end
    mem_resp = 1'b1;
    step();
    mem_resp = 1'b0;
    expect_sig("nowd.f3_load_ir", S_LOAD_IR, 32'd1);
    step();
    step();
`endif
    expect_sig("wdtail.load_rf", S_LOAD_RF, 32'd1);
    step();

    step();
    step();
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: actual=%0d pending required=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

endmodule
`default_nettype wire
